// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Index width for n entries; never below 1 so a 1-bit pointer still exists.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_dff.sv
// W-wide D-type register with load enable and async active-low reset.
module shared_reg_arbiter_dff #(
  parameter int unsigned     W         = 8,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping.
module shared_reg_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [PW-1:0] winner_c,
  output logic          valid_c
);

  localparam int unsigned DW = 2 * N;

  logic [DW-1:0] dbl_c;

  // Upper copy of req supplies the wrapped-around candidates.
  always_comb begin
    dbl_c    = {req, req} & ~((DW'(1) << rr_ptr) - DW'(1));
    winner_c = '0;
    for (int i = int'(DW) - 1; i >= 0; i--) begin
      if (dbl_c[i]) winner_c = (i >= int'(N)) ? PW'(i - int'(N)) : PW'(i);
    end
    valid_c = |req;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting N requesters write access to one shared register.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned  N         = 4,
  parameter int unsigned  W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wr_data,
  output logic [N-1:0]   grant,
  output logic           ack,
  output logic [W-1:0]   q,
  output logic           busy
);

  localparam int unsigned PW = clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] winner_q, winner_d;

  logic [PW-1:0] pick_winner_c;
  logic          pick_valid_c;
  logic          load_c;
  logic [W-1:0]  slot_c;

  shared_reg_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .winner_c (pick_winner_c),
    .valid_c  (pick_valid_c)
  );

  always_comb begin
    slot_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (winner_q == PW'(i)) slot_c = wr_data[i*W +: W];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    load_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          winner_d = pick_winner_c;
          grant_d  = N'(1) << pick_winner_c;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped request aborts without advancing the pointer.
        if (req[winner_q]) begin
          load_c  = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        grant_d  = '0;
        rr_ptr_d = (winner_q == PW'(N - 1)) ? '0 : winner_q + PW'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
    end
  end

  shared_reg_arbiter_dff #(.W(W), .RESET_VAL(RESET_VAL)) u_reg (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (load_c),
    .d     (slot_c),
    .q     (q)
  );

  assign grant = grant_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter with a transaction-level round-robin model.
module tb_shared_reg_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'h00;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [N*W-1:0] wr_data = '0;
  logic [N-1:0]   grant;
  logic           ack;
  logic [W-1:0]   q;
  logic           busy;

  shared_reg_arbiter #(.N(N), .W(W), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wr_data (wr_data),
    .grant   (grant),
    .ack     (ack),
    .q       (q),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp     = 0;
  int           n_err     = 0;
  int           ack_count = 0;
  int           exp_acks  = 0;
  int           m_ptr     = 0;
  logic [W-1:0] m_q       = RV;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: first requester at or after the pointer, counting modulo N.
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      int idx;
      idx = (ptr + k) % int'(N);
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  // Monitor: every ack must match the oldest pending expected write.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      if (ack === 1'b1) begin
        ack_count++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got ack=1 grant=%0h expected no ack", grant);
        end else begin
          e = sb.pop_front();
          check("ack_grant", 32'(grant), 32'(e.g));
          check("ack_q", 32'(q), 32'(e.d));
        end
      end
    end
  end

  // Caller is at a negedge with the DUT idle; returns at the negedge after the round.
  task automatic do_round(input logic [N-1:0] pat, input logic [N*W-1:0] data, input bit abort);
    int           w;
    logic [N-1:0] oh;
    logic [W-1:0] d;
    exp_t         e;
    req     = pat;
    wr_data = data;
    w       = pick(pat, m_ptr);
    oh      = N'(1) << w;
    d       = data[w*W +: W];
    if (!abort) begin
      e.g = oh;
      e.d = d;
      sb.push_back(e);
    end
    @(negedge clk);
    check("grant", 32'(grant), 32'(oh));
    check("busy_grant", 32'(busy), 32'd1);
    if (abort) begin
      req = pat & ~oh;
      @(negedge clk);
      check("abort_grant", 32'(grant), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_q", 32'(q), 32'(m_q));
      check("abort_acks", 32'(ack_count), 32'(exp_acks));
    end else begin
      @(negedge clk);
      exp_acks++;
      m_q = d;
      check("ack_count", 32'(ack_count), 32'(exp_acks));
      check("ack_high", 32'(ack), 32'd1);
      check("grant_in_ack", 32'(grant), 32'(oh));
      check("q", 32'(q), 32'(m_q));
      @(negedge clk);
      check("ack_low", 32'(ack), 32'd0);
      check("grant_clear", 32'(grant), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
      m_ptr = (w + 1) % int'(N);
    end
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
    end
  endtask

  initial begin
    logic [N-1:0]   pat;
    logic [N*W-1:0] data;
    bit             ab;

    // Reset held with all requesting.
    req     = '1;
    wr_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_q", 32'(q), 32'(RV));
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    do_round(4'b1111, 32'h44332211, 1'b0);

    do_round(4'b0100, 32'h00A50000, 1'b0);
    repeat (5) do_round(4'b1111, 32'h44332211, 1'b0);

    do_round(4'b0010, 32'h00005500, 1'b1);
    do_round(4'b0011, 32'h00006677, 1'b0);

    do_round(4'b1000, 32'h9A000000, 1'b0);
    do_round(4'b1001, 32'hBC0000DE, 1'b0);

    // Asynchronous reset during GRANT, between clock edges.
    req     = 4'b0100;
    wr_data = 32'h00C30000;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_ack", 32'(ack), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_q", 32'(q), 32'(RV));
    m_ptr = 0;
    m_q   = RV;
    @(negedge clk);
    req     = '0;
    reset_n = 1'b1;
    idle(2);
    check("async_no_ack", 32'(ack_count), 32'(exp_acks));

    for (int r = 0; r < 60; r++) begin
      idle(int'($urandom_range(0, 2)));
      pat = N'($urandom_range(1, (1 << N) - 1));
      for (int s = 0; s < int'(N); s++) data[s*W +: W] = W'($urandom);
      ab = ($urandom_range(0, 4) == 0);
      do_round(pat, data, ab);
    end

    idle(2);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_acks", 32'(ack_count), 32'(exp_acks));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
